// File: rtl/line_pingpong_scaler_pkg.sv
// Pixel format and default geometry shared by the line ping-pong scaler
// and the neighbouring VGA/TMDS blocks (pixels are packed {blue,green,red}).
package line_pingpong_scaler_pkg;

    localparam int PIX_W_DEF = 24;
    localparam int SRC_W_DEF = 256;
    localparam int CH_W      = 8;
    localparam int RED_LSB   = 0;
    localparam int GREEN_LSB = 8;
    localparam int BLUE_LSB  = 16;

    function automatic logic [PIX_W_DEF-1:0] pack_bgr(input logic [CH_W-1:0] r,
                                                      input logic [CH_W-1:0] g,
                                                      input logic [CH_W-1:0] b);
        logic [PIX_W_DEF-1:0] p;
        p = '0;
        p[RED_LSB   +: CH_W] = r;
        p[GREEN_LSB +: CH_W] = g;
        p[BLUE_LSB  +: CH_W] = b;
        return p;
    endfunction

    localparam logic [PIX_W_DEF-1:0] BORDER_DEF = pack_bgr(8'h00, 8'h00, 8'h00);

endpackage

// File: rtl/line_pingpong_scaler_line_ram_dp.sv
// Simple dual-port line RAM holding both ping-pong banks; the address MSB is
// the bank select. One write port, one registered read port, contents not reset.
module line_ram_dp
    import line_pingpong_scaler_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int ADDR_W = 9
) (
    input  logic              pclk,
    input  logic              we,
    input  logic [ADDR_W:0]   waddr,
    input  logic [PIX_W-1:0]  wdata,
    input  logic [ADDR_W:0]   raddr,
    output logic [PIX_W-1:0]  rdata_p1
);

    logic [PIX_W-1:0] mem [2*2**ADDR_W];

    always_ff @(posedge pclk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata_p1 <= mem[raddr];
    end

endmodule

// File: rtl/line_pingpong_scaler.sv
// Ping-pong line buffer between the PPU pixel stream and the display path:
// captures a source line per bank and replays it with H/V pixel repetition.
module line_pingpong_scaler
    import line_pingpong_scaler_pkg::*;
#(
    parameter int               PIX_W    = PIX_W_DEF,
    parameter int               SRC_W    = SRC_W_DEF,
    parameter int               ADDR_W   = 9,
    parameter int               H_REPEAT = 2,
    parameter int               V_REPEAT = 2,
    parameter logic [PIX_W-1:0] BORDER   = PIX_W'(BORDER_DEF)
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [PIX_W-1:0]  in_data,
    input  logic              in_eol,
    input  logic              in_sof,
    input  logic              rd_line_start,
    input  logic              rd_active,
    output logic [PIX_W-1:0]  out_data,
    output logic              out_valid,
    output logic              underrun,
    output logic              overrun
);

    localparam int CNT_W = $clog2(SRC_W + 1);
    localparam int REP_W = $clog2(V_REPEAT + 1);
    localparam int HS_W  = $clog2(H_REPEAT + 1);

    logic             wr_bank, rd_bank, line_ready;
    logic [CNT_W-1:0] wr_addr, rd_addr;
    logic [REP_W-1:0] rep_cnt;
    logic [HS_W-1:0]  h_sub;

    logic             wr_en, wr_drop, rep_last, h_last;
    logic [PIX_W-1:0] ram_q_p1;
    logic             vld_p1, border_p1;

    // Read address stops one past the last source pixel; that value selects the border.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a);
        return (a == CNT_W'(SRC_W)) ? a : a + CNT_W'(1);
    endfunction

    always_comb begin
        wr_drop  = in_valid && !in_sof && (line_ready || wr_addr == CNT_W'(SRC_W));
        wr_en    = in_valid && !in_sof && !line_ready && (wr_addr < CNT_W'(SRC_W));
        rep_last = (rep_cnt == REP_W'(V_REPEAT - 1));
        h_last   = (h_sub == HS_W'(H_REPEAT - 1));
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b1;
            wr_addr    <= '0;
            line_ready <= 1'b0;
            rep_cnt    <= '0;
            h_sub      <= '0;
            rd_addr    <= '0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            underrun <= 1'b0;
            overrun  <= wr_drop;

            // Write side; a pixel coinciding with eol lands before the line closes.
            if (in_sof) begin
                wr_addr    <= '0;
                line_ready <= 1'b0;
            end else begin
                if (wr_en)
                    wr_addr <= wr_addr + CNT_W'(1);
                if (in_eol && !line_ready) begin
                    line_ready <= 1'b1;
                    wr_addr    <= '0;
                end
            end

            // Line repeat / bank swap; sof forces the next line start to attempt a swap.
            if (in_sof) begin
                rep_cnt <= REP_W'(V_REPEAT - 1);
            end else if (rd_line_start) begin
                if (rep_last) begin
                    rep_cnt <= '0;
                    if (line_ready) begin
                        rd_bank    <= wr_bank;
                        wr_bank    <= ~wr_bank;
                        line_ready <= 1'b0;
                    end else begin
                        underrun <= 1'b1;
                    end
                end else begin
                    rep_cnt <= rep_cnt + REP_W'(1);
                end
            end

            if (rd_line_start) begin
                h_sub   <= '0;
                rd_addr <= '0;
            end else if (rd_active) begin
                if (h_last) begin
                    h_sub   <= '0;
                    rd_addr <= sat_inc(rd_addr);
                end else begin
                    h_sub <= h_sub + HS_W'(1);
                end
            end
        end
    end

    line_ram_dp #(
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .pclk     (pclk),
        .we       (wr_en),
        .waddr    ({wr_bank, ADDR_W'(wr_addr)}),
        .wdata    (in_data),
        .raddr    ({rd_bank, ADDR_W'(rd_addr)}),
        .rdata_p1 (ram_q_p1)
    );

    // ---- stage p1: RAM data and its select flags arrive together ----
    always_ff @(posedge pclk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            border_p1 <= 1'b0;
        end else begin
            vld_p1    <= rd_active;
            border_p1 <= (rd_addr == CNT_W'(SRC_W));
        end
    end

    always_comb begin
        out_valid = vld_p1;
        out_data  = '0;
        if (vld_p1)
            out_data = border_p1 ? BORDER : ram_q_p1;
    end

endmodule

// File: tb/tb_line_pingpong_scaler.sv
// Bench for line_pingpong_scaler: default instance plus a 1:1 (H=V=1, 640-wide) instance,
// random pixel lines checked against a line-level model of the ping-pong behaviour.
`timescale 1ns/1ps
module tb_line_pingpong_scaler;

    localparam int SRC = 256;
    localparam int H   = 2;
    localparam int V   = 2;
    localparam int ACT = 640;
    localparam int BSRC = 640;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic        in_valid = 0, in_eol = 0, in_sof = 0, rd_line_start = 0, rd_active = 0;
    logic [23:0] in_data = '0;
    logic [23:0] out_data;
    logic        out_valid, underrun, overrun;

    logic        b_in_valid = 0, b_in_eol = 0, b_in_sof = 0, b_rd_line_start = 0, b_rd_active = 0;
    logic [23:0] b_in_data = '0;
    logic [23:0] b_out_data;
    logic        b_out_valid, b_underrun, b_overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int under_seen = 0, over_seen = 0, b_under_seen = 0, b_over_seen = 0;

    // line-level reference model for the default instance
    logic [23:0] m_wbuf  [SRC];
    logic [23:0] m_pend  [SRC];
    logic [23:0] m_shown [SRC];
    int  m_wcnt = 0, m_rep = 0;
    bit  m_ready = 0, m_known = 0;
    int  exp_under = 0, exp_over = 0;

    logic [23:0] b_line [BSRC];

    always #5 pclk = ~pclk;

    line_pingpong_scaler dut (
        .pclk(pclk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_eol(in_eol),
        .in_sof(in_sof), .rd_line_start(rd_line_start), .rd_active(rd_active),
        .out_data(out_data), .out_valid(out_valid), .underrun(underrun), .overrun(overrun)
    );

    line_pingpong_scaler #(.SRC_W(BSRC), .ADDR_W(10), .H_REPEAT(1), .V_REPEAT(1)) dut_b (
        .pclk(pclk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data), .in_eol(b_in_eol),
        .in_sof(b_in_sof), .rd_line_start(b_rd_line_start), .rd_active(b_rd_active),
        .out_data(b_out_data), .out_valid(b_out_valid), .underrun(b_underrun), .overrun(b_overrun)
    );

    always @(negedge pclk) begin
        if (underrun === 1'b1)   under_seen++;
        if (overrun === 1'b1)    over_seen++;
        if (b_underrun === 1'b1) b_under_seen++;
        if (b_overrun === 1'b1)  b_over_seen++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_wcnt = 0; m_rep = 0; m_ready = 0; m_known = 0;
    endfunction

    function automatic void model_sof();
        m_wcnt = 0; m_ready = 0; m_rep = V - 1;
    endfunction

    function automatic void model_pixel(input logic [23:0] d);
        if (m_ready || m_wcnt == SRC) exp_over++;
        else begin m_wbuf[m_wcnt] = d; m_wcnt++; end
    endfunction

    function automatic void model_eol();
        if (!m_ready) begin m_pend = m_wbuf; m_ready = 1; m_wcnt = 0; end
    endfunction

    function automatic void model_line_start();
        if (m_rep == V - 1) begin
            m_rep = 0;
            if (m_ready) begin m_shown = m_pend; m_ready = 0; m_known = 1; end
            else exp_under++;
        end else m_rep++;
    endfunction

    // k-th active display pixel: each source pixel shown H times, border past the image
    function automatic logic [23:0] exp_pix(input int k);
        int src;
        src = k / H;
        return (src < SRC) ? m_shown[src] : 24'h0;
    endfunction

    task automatic pulse_sof();
        @(negedge pclk); in_sof = 1; model_sof();
        @(negedge pclk); in_sof = 0;
    endtask

    task automatic pulse_eol();
        @(negedge pclk); in_eol = 1; model_eol();
        @(negedge pclk); in_eol = 0;
    endtask

    task automatic write_line(input int n, input bit ramp, input bit eol_last);
        logic [23:0] d;
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            d = ramp ? 24'(i) : 24'($urandom);
            in_valid = 1; in_data = d; in_eol = eol_last && (i == n - 1);
            model_pixel(d);
            if (in_eol) model_eol();
        end
        @(negedge pclk); in_valid = 0; in_eol = 0;
    endtask

    task automatic display_line();
        logic [23:0] e;
        @(negedge pclk); rd_line_start = 1; model_line_start();
        for (int k = 0; k <= ACT; k++) begin
            @(negedge pclk);
            rd_line_start = 0;
            if (k > 0) begin
                e = exp_pix(k - 1);
                n_checks++;
                if (out_valid !== 1'b1 || (m_known && out_data !== e)) begin
                    n_fail++;
                    $display("FAIL pixel %0d: got valid=%b data=%h, want valid=1 data=%h", k - 1, out_valid, out_data, e);
                end
            end
            rd_active = (k < ACT);
        end
        @(negedge pclk);
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 24'h0) begin
            n_fail++;
            $display("FAIL blank after line: got valid=%b data=%h, want 0/000000", out_valid, out_data);
        end
    endtask

    task automatic check_flag_counts(input string name);
        repeat (3) @(negedge pclk);
        n_checks++;
        if (under_seen !== exp_under) begin
            n_fail++;
            $display("FAIL %s underrun count: got %0d, want %0d", name, under_seen, exp_under);
        end
        n_checks++;
        if (over_seen !== exp_over) begin
            n_fail++;
            $display("FAIL %s overrun count: got %0d, want %0d", name, over_seen, exp_over);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        model_reset();
        repeat (3) @(negedge pclk);
        n_checks++;
        if ({out_valid, out_data, underrun, overrun} !== 27'h0) begin
            n_fail++;
            $display("FAIL reset outputs: got valid=%b data=%h ur=%b or=%b, want all 0", out_valid, out_data, underrun, overrun);
        end
        n_checks++;
        if ({b_out_valid, b_out_data, b_underrun, b_overrun} !== 27'h0) begin
            n_fail++;
            $display("FAIL reset outputs b: got valid=%b data=%h ur=%b or=%b, want all 0", b_out_valid, b_out_data, b_underrun, b_overrun);
        end
        rst = 0;
        @(negedge pclk);
    endtask

    task automatic test_basic();
        pulse_sof();
        write_line(SRC, 1'b1, 1'b1);
        display_line();
        display_line();
        check_flag_counts("basic");
    endtask

    task automatic test_back_to_back();
        pulse_sof();
        write_line(SRC, 1'b0, 1'b1);
        fork
            display_line();
            begin
                repeat (3) @(negedge pclk);
                write_line(SRC, 1'b0, 1'b1);
            end
        join
        display_line();
        display_line();
        display_line();
        check_flag_counts("back_to_back");
    endtask

    task automatic test_underrun();
        pulse_sof();
        write_line(SRC, 1'b0, 1'b1);
        display_line();
        display_line();
        display_line();
        check_flag_counts("underrun");
    endtask

    task automatic test_overrun();
        pulse_sof();
        write_line(300, 1'b0, 1'b0);
        pulse_eol();
        write_line(5, 1'b0, 1'b0);
        display_line();
        display_line();
        check_flag_counts("overrun");
    endtask

    task automatic test_reset_midline();
        logic [23:0] e;
        pulse_sof();
        write_line(SRC, 1'b0, 1'b1);
        @(negedge pclk); rd_line_start = 1; model_line_start();
        for (int k = 0; k <= 100; k++) begin
            @(negedge pclk);
            rd_line_start = 0;
            if (k > 0) begin
                e = exp_pix(k - 1);
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== e) begin
                    n_fail++;
                    $display("FAIL pre-reset pixel %0d: got valid=%b data=%h, want 1/%h", k - 1, out_valid, out_data, e);
                end
            end
            rd_active = 1;
        end
        rst = 1;
        @(negedge pclk);
        n_checks++;
        if ({out_valid, out_data, underrun, overrun} !== 27'h0) begin
            n_fail++;
            $display("FAIL mid-line reset outputs: got valid=%b data=%h ur=%b or=%b, want all 0", out_valid, out_data, underrun, overrun);
        end
        rst = 0; rd_active = 0;
        model_reset();
        pulse_sof();
        write_line(SRC, 1'b0, 1'b1);
        display_line();
        display_line();
        check_flag_counts("reset_midline");
    endtask

    task automatic b_write_line();
        for (int i = 0; i < BSRC; i++) begin
            @(negedge pclk);
            b_line[i] = 24'($urandom);
            b_in_valid = 1; b_in_data = b_line[i]; b_in_eol = (i == BSRC - 1);
        end
        @(negedge pclk); b_in_valid = 0; b_in_eol = 0;
    endtask

    task automatic b_display_line(input string name);
        int bad;
        bad = 0;
        @(negedge pclk); b_rd_line_start = 1;
        for (int k = 0; k <= BSRC; k++) begin
            @(negedge pclk);
            b_rd_line_start = 0;
            if (k > 0) begin
                n_checks++;
                if (b_out_valid !== 1'b1 || b_out_data !== b_line[k - 1]) begin
                    n_fail++;
                    $display("FAIL %s pixel %0d: got valid=%b data=%h, want 1/%h", name, k - 1, b_out_valid, b_out_data, b_line[k - 1]);
                end
            end
            b_rd_active = (k < BSRC);
        end
    endtask

    task automatic test_unity();
        @(negedge pclk); b_in_sof = 1;
        @(negedge pclk); b_in_sof = 0;
        b_write_line();
        b_display_line("unity line1");
        b_write_line();
        b_display_line("unity line2");
        b_display_line("unity replay");
        repeat (3) @(negedge pclk);
        n_checks++;
        if (b_under_seen !== 1 || b_over_seen !== 0) begin
            n_fail++;
            $display("FAIL unity flags: got underruns=%0d overruns=%0d, want 1/0", b_under_seen, b_over_seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_underrun();
        test_overrun();
        test_unity();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
